// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and one-shot access sequencer for data memory.
// Optional DMEM_ARB_LOCK_EN lets requester 1 hold the grant across transactions.
module dmem_arbiter #(
   parameter int   XLEN       = 32,
   parameter logic RESET_LAST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic [XLEN-1:0] r0_addr,
   input  logic [XLEN-1:0] r0_wdata,
   input  logic            r0_we,
   input  logic [2:0]      r0_funct3,
   output logic            r0_rsp_valid,
   input  logic            r0_rsp_ready,
   output logic [XLEN-1:0] r0_rsp_rdata,
   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic [XLEN-1:0] r1_addr,
   input  logic [XLEN-1:0] r1_wdata,
   input  logic            r1_we,
   input  logic [2:0]      r1_funct3,
   output logic            r1_rsp_valid,
   input  logic            r1_rsp_ready,
   output logic [XLEN-1:0] r1_rsp_rdata,
   input  logic            r1_lock,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_write_data,
   output logic            mem_read,
   output logic            mem_write,
   output logic [2:0]      mem_funct3,
   input  logic [XLEN-1:0] mem_read_data,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state;
   logic            last_grant;
   logic            owner;
   logic            lat_we;
   logic [2:0]      lat_f3;
   logic [XLEN-1:0] lat_addr;
   logic [XLEN-1:0] lat_wdata;
   logic [XLEN-1:0] rsp_rdata;
   logic            acc_rd;
   logic            acc_wr;
   logic            lock_only;
   logic            gnt0;
   logic            gnt1;
   logic            take;
   logic            rsp_hs;

`ifdef DMEM_ARB_LOCK_EN
   logic lock_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q <= 1'b0;
      end else if (rsp_hs && owner && r1_lock) begin
         lock_q <= 1'b1;
      end else if (state == IDLE && !r1_lock) begin
         lock_q <= 1'b0;
      end
   end

   assign lock_only = lock_q;
`else
   logic unused_lock;

   assign unused_lock = r1_lock;
   assign lock_only   = 1'b0;
`endif

   // last_grant == 1 means requester 1 went last, so requester 0 wins a tie
   always_comb begin
      gnt0 = r0_valid && !lock_only && (!r1_valid || last_grant);
      gnt1 = r1_valid && (lock_only || !r0_valid || !last_grant);
   end

   assign r0_ready = (state == IDLE) && gnt0;
   assign r1_ready = (state == IDLE) && gnt1;
   assign take     = r0_ready || r1_ready;
   assign rsp_hs   = (state == RESP) &&
                     (owner ? r1_rsp_ready : r0_rsp_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= RESET_LAST;
         owner      <= 1'b0;
         lat_we     <= 1'b0;
         lat_f3     <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rsp_rdata  <= '0;
         acc_rd     <= 1'b0;
         acc_wr     <= 1'b0;
      end else begin
         acc_rd <= 1'b0;
         acc_wr <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take) begin
                  owner      <= gnt1;
                  last_grant <= gnt1;
                  lat_addr   <= gnt1 ? r1_addr : r0_addr;
                  lat_wdata  <= gnt1 ? r1_wdata : r0_wdata;
                  lat_we     <= gnt1 ? r1_we : r0_we;
                  lat_f3     <= gnt1 ? r1_funct3 : r0_funct3;
                  acc_rd     <= gnt1 ? !r1_we : !r0_we;
                  acc_wr     <= gnt1 ? r1_we : r0_we;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               rsp_rdata <= lat_we ? '0 : mem_read_data;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_hs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_addr       = lat_addr;
   assign mem_write_data = lat_wdata;
   assign mem_funct3     = lat_f3;
   assign mem_read       = acc_rd;
   assign mem_write      = acc_wr;
   assign r0_rsp_valid   = (state == RESP) && !owner;
   assign r1_rsp_valid   = (state == RESP) && owner;
   assign r0_rsp_rdata   = rsp_rdata;
   assign r1_rsp_rdata   = rsp_rdata;
   assign busy           = (state != IDLE);

endmodule
